// File: rtl/sgmii_rx_rate_adapt_if.sv
// GMII-side bundle between the SGMII PCS receive path and the MAC-facing de-replicator.
// No storage; master drives the replicated PCS byte stream, slave returns the de-replicated strobe stream.
// No backpressure: the rx side is free-running and mac_en is a pure sample strobe.
interface sgmii_rx_rate_adapt_if;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic       mac_en;
  logic [7:0] mac_data;
  logic       mac_dv;
  logic       mac_er;

  modport master (
    output rx_data, rx_dv, rx_er,
    input  mac_en, mac_data, mac_dv, mac_er
  );

  modport slave (
    input  rx_data, rx_dv, rx_er,
    output mac_en, mac_data, mac_dv, mac_er
  );
endinterface

// File: rtl/sgmii_rx_rate_adapt.sv
// De-replicates the SGMII receive byte stream (x1/x10/x100) into one mac_en strobe per byte.
// Latency: one cycle from the sampled rx cycle to mac_*; all outputs are registered.
// No backpressure: mac_en is a one-cycle strobe the consumer must take when it fires.
module sgmii_rx_rate_adapt (
  input  logic                         Clk_125M,
  input  logic                         rst,
  input  logic [2:0]                   Speed,
  sgmii_rx_rate_adapt_if.slave         gmii,
  output logic                         align_err,
  output logic                         speed_err,
  output logic [7:0]                   align_err_cnt
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d, cnt_max, cnt_adv;
  logic [2:0] speed_q;
  logic       rx_dv_q;
  logic       speed_ok, speed_chg, at_zero;
  logic       smp, smp_dv, smp_er, aerr_d, drop_dv;

  always_comb begin
    cnt_max = 7'd0;
    unique case (Speed)
      3'b100:  cnt_max = 7'd0;
      3'b010:  cnt_max = 7'd9;
      3'b001:  cnt_max = 7'd99;
      default: cnt_max = 7'd0;
    endcase
  end

  assign speed_ok  = (Speed == 3'b100) || (Speed == 3'b010) || (Speed == 3'b001);
  assign speed_chg = (Speed != speed_q);
  assign at_zero   = (cnt_q == 7'd0);
  assign cnt_adv   = (cnt_q >= cnt_max) ? 7'd0 : 7'(cnt_q + 7'd1);
  assign speed_err = !((speed_q == 3'b100) || (speed_q == 3'b010) || (speed_q == 3'b001));

  always_ff @(posedge Clk_125M) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      speed_q <= 3'b100;
      rx_dv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      speed_q <= Speed;
      rx_dv_q <= gmii.rx_dv;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_adv;
    smp     = 1'b0;
    smp_dv  = gmii.rx_dv;
    smp_er  = gmii.rx_er;
    aerr_d  = 1'b0;
    drop_dv = 1'b0;
    if (!speed_ok) begin
      // Illegal rate: park, and drop the frame qualifier without a strobe.
      state_d = IDLE;
      cnt_d   = 7'd0;
      drop_dv = 1'b1;
    end else if (speed_chg) begin
      state_d = IDLE;
      cnt_d   = 7'd0;
      if (state_q == FRAME) begin
        smp    = 1'b1;
        smp_dv = 1'b0;
        smp_er = 1'b1;
      end
    end else if (state_q == IDLE) begin
      if (gmii.rx_dv && !rx_dv_q) begin
        // Frame start re-phases the counter so the first byte lands on a sample point.
        smp     = 1'b1;
        state_d = FRAME;
        cnt_d   = (cnt_max == 7'd0) ? 7'd0 : 7'd1;
      end else begin
        smp = at_zero;
      end
    end else begin
      if (gmii.rx_dv) begin
        smp = at_zero;
      end else if (at_zero) begin
        smp     = 1'b1;
        state_d = IDLE;
      end else begin
        smp     = 1'b1;
        smp_dv  = 1'b0;
        smp_er  = 1'b0;
        aerr_d  = 1'b1;
        cnt_d   = 7'd0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk_125M) begin
    if (rst) begin
      gmii.mac_en   <= 1'b0;
      gmii.mac_data <= 8'h00;
      gmii.mac_dv   <= 1'b0;
      gmii.mac_er   <= 1'b0;
      align_err     <= 1'b0;
      align_err_cnt <= 8'h00;
    end else begin
      gmii.mac_en <= smp;
      align_err   <= aerr_d;
      if (smp) begin
        gmii.mac_data <= gmii.rx_data;
        gmii.mac_dv   <= smp_dv;
        gmii.mac_er   <= smp_er;
      end else if (drop_dv) begin
        gmii.mac_dv <= 1'b0;
      end
      if (aerr_d && (align_err_cnt != 8'hFF)) begin
        align_err_cnt <= 8'(align_err_cnt + 8'd1);
      end
    end
  end

endmodule

// File: tb/tb_sgmii_rx_rate_adapt.sv
// Bench for sgmii_rx_rate_adapt: directed rate scenarios plus randomized traffic,
// scored against a phase-anchor reference model through strobe and status queues.
module tb_sgmii_rx_rate_adapt;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] speed;
  logic       align_err, speed_err;
  logic [7:0] align_err_cnt;

  sgmii_rx_rate_adapt_if ifc();

  sgmii_rx_rate_adapt dut (
    .Clk_125M      (clk),
    .rst           (rst),
    .Speed         (speed),
    .gmii          (ifc.slave),
    .align_err     (align_err),
    .speed_err     (speed_err),
    .align_err_cnt (align_err_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int stamp; logic [7:0] data; logic dv; logic er; logic aerr; } strobe_t;
  typedef struct { int stamp; logic rst; logic serr; logic [7:0] aecnt; } status_t;

  strobe_t sq[$];
  status_t stq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_en = 0, n_dv = 0, n_er = 0, n_aerr = 0;

  // Reference model: a byte is sampled whenever (cycle - anchor) is a multiple of N.
  int         anchor = 0;
  bit         in_frame = 0;
  bit         prev_dv = 0;
  logic [2:0] sp_prev = 3'b100;
  int         aerr_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rate_n(input logic [2:0] s);
    case (s)
      3'b100:  return 1;
      3'b010:  return 10;
      3'b001:  return 100;
      default: return 0;
    endcase
  endfunction

  task automatic emit(input int stamp, input logic [7:0] d, input logic dv, input logic er, input logic ae);
    strobe_t e;
    e.stamp = stamp; e.data = d; e.dv = dv; e.er = er; e.aerr = ae;
    sq.push_back(e);
  endtask

  task automatic model(input logic r, input logic [2:0] sp, input logic [7:0] d, input logic dv, input logic er);
    int k;
    int n;
    bit ph0;
    status_t s;
    k = cyc;
    if (r) begin
      anchor = k + 1; in_frame = 0; prev_dv = 0; sp_prev = 3'b100; aerr_m = 0;
      s.stamp = k + 1; s.rst = 1'b1; s.serr = 1'b0; s.aecnt = 8'h00;
      stq.push_back(s);
    end else begin
      n = rate_n(sp);
      if (n == 0) begin
        anchor = k + 1; in_frame = 0;
      end else if (sp != sp_prev) begin
        if (in_frame) emit(k + 1, d, 1'b0, 1'b1, 1'b0);
        anchor = k + 1; in_frame = 0;
      end else begin
        ph0 = ((k - anchor) % n) == 0;
        if (!in_frame) begin
          if (dv && !prev_dv) begin
            emit(k + 1, d, 1'b1, er, 1'b0);
            anchor = k; in_frame = 1;
          end else if (ph0) begin
            emit(k + 1, d, dv, er, 1'b0);
          end
        end else if (dv) begin
          if (ph0) emit(k + 1, d, 1'b1, er, 1'b0);
        end else if (ph0) begin
          emit(k + 1, d, 1'b0, er, 1'b0);
          in_frame = 0;
        end else begin
          emit(k + 1, d, 1'b0, 1'b0, 1'b1);
          if (aerr_m < 255) aerr_m++;
          anchor = k + 1; in_frame = 0;
        end
      end
      prev_dv = dv;
      sp_prev = sp;
      s.stamp = k + 1; s.rst = 1'b0; s.serr = (n == 0); s.aecnt = 8'(aerr_m);
      stq.push_back(s);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] sp, input logic [7:0] d, input logic dv, input logic er);
    rst = r; speed = sp; ifc.rx_data = d; ifc.rx_dv = dv; ifc.rx_er = er;
    model(r, sp, d, dv, er);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] sp, input int n);
    repeat (n) drive(1'b0, sp, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [2:0] sp, input int cycles, input int n);
    for (int i = 0; i < cycles; i++) drive(1'b0, sp, 8'(i / n), 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  status_t ms;
  strobe_t me;
  logic    exp_en;

  always @(negedge clk) begin
    if (stq.size() > 0 && stq[0].stamp == cyc) begin
      ms = stq.pop_front();
      while (sq.size() > 0 && sq[0].stamp < cyc) begin
        checks++; errors++;
        $display("FAIL missing_strobe: expected strobe at cycle %0d not seen", sq[0].stamp);
        void'(sq.pop_front());
      end
      exp_en = (sq.size() > 0) && (sq[0].stamp == cyc);
      checks++;
      if (ifc.mac_en !== exp_en) begin
        errors++;
        $display("FAIL mac_en cycle %0d: got %b expected %b", cyc, ifc.mac_en, exp_en);
      end
      checks++;
      if (exp_en) begin
        me = sq.pop_front();
        if ({ifc.mac_data, ifc.mac_dv, ifc.mac_er, align_err} !== {me.data, me.dv, me.er, me.aerr}) begin
          errors++;
          $display("FAIL strobe cycle %0d: got data=%h dv=%b er=%b aerr=%b expected data=%h dv=%b er=%b aerr=%b",
                   cyc, ifc.mac_data, ifc.mac_dv, ifc.mac_er, align_err, me.data, me.dv, me.er, me.aerr);
        end
      end else if (align_err !== 1'b0) begin
        errors++;
        $display("FAIL align_err cycle %0d: got %b expected 0", cyc, align_err);
      end
      checks++;
      if ({speed_err, align_err_cnt} !== {ms.serr, ms.aecnt}) begin
        errors++;
        $display("FAIL status cycle %0d: got speed_err=%b cnt=%0d expected speed_err=%b cnt=%0d",
                 cyc, speed_err, align_err_cnt, ms.serr, ms.aecnt);
      end
      if (ms.rst) begin
        checks++;
        if ({ifc.mac_data, ifc.mac_dv, ifc.mac_er} !== 10'h000) begin
          errors++;
          $display("FAIL reset_outputs cycle %0d: got data=%h dv=%b er=%b expected zeros",
                   cyc, ifc.mac_data, ifc.mac_dv, ifc.mac_er);
        end
      end
      if (ifc.mac_en === 1'b1) begin
        n_en++;
        if (ifc.mac_dv === 1'b1) n_dv++;
        if (ifc.mac_er === 1'b1) n_er++;
      end
      if (align_err === 1'b1) n_aerr++;
    end
  end

  logic [2:0] good_sp [3];
  logic [2:0] bad_sp  [5];

  initial begin
    int b0, b1;
    logic [2:0] sp;
    good_sp = '{3'b100, 3'b010, 3'b001};
    bad_sp  = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    repeat (4) drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);

    // 100 Mb/s aligned 64-byte frame
    idle(3'b010, 10);
    b0 = n_dv; b1 = n_aerr;
    frame(3'b010, 640, 10);
    idle(3'b010, 30);
    chk("r100_dv_strobes", n_dv - b0, 64);
    chk("r100_no_align_err", n_aerr - b1, 0);
    chk("r100_align_cnt", int'(align_err_cnt), 0);

    // 10 Mb/s frame ending 37 cycles into the third byte
    repeat (2) drive(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    idle(3'b001, 5);
    b1 = n_aerr;
    frame(3'b001, 237, 100);
    idle(3'b001, 150);
    chk("r10_align_pulses", n_aerr - b1, 1);
    chk("r10_align_cnt", int'(align_err_cnt), 1);

    // 1000 Mb/s back-to-back frames, every cycle is a strobe
    idle(3'b100, 4);
    b0 = n_en; b1 = 0;
    repeat (3) begin
      int len;
      len = 20 + $urandom_range(0, 40);
      frame(3'b100, len, 1);
      idle(3'b100, 12);
      b1 += len + 12;
    end
    chk("r1000_strobes", n_en - b0, b1);

    // rate change mid-frame, then a frame at the new rate
    idle(3'b010, 5);
    b0 = n_er;
    frame(3'b010, 53, 10);
    repeat (5) drive(1'b0, 3'b001, 8'h5A, 1'b1, 1'b0);
    idle(3'b001, 30);
    chk("rate_change_er_strobe", n_er - b0, 1);
    b0 = n_dv;
    frame(3'b001, 300, 100);
    idle(3'b001, 120);
    chk("after_change_dv_strobes", n_dv - b0, 3);

    // illegal rate select, then recovery
    idle(3'b100, 5);
    repeat (2) drive(1'b0, 3'b011, 8'($urandom), 1'b0, 1'b0);
    b0 = n_en;
    repeat (18) drive(1'b0, 3'b011, 8'($urandom), 1'b0, 1'b0);
    chk("bad_speed_no_strobes", n_en - b0, 0);
    chk("bad_speed_err", int'(speed_err), 1);
    idle(3'b100, 10);
    chk("good_speed_err", int'(speed_err), 0);

    // saturate the alignment error counter, then clear by reset
    idle(3'b010, 5);
    repeat (300) begin
      frame(3'b010, 13, 10);
      idle(3'b010, 5);
    end
    chk("align_cnt_saturated", int'(align_err_cnt), 255);
    repeat (2) drive(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    chk("align_cnt_cleared", int'(align_err_cnt), 0);

    // randomized traffic with rate changes, illegal rates and resets
    sp = 3'b100;
    for (int seg = 0; seg < 80; seg++) begin
      int flen, ilen;
      if ($urandom_range(0, 19) == 0) sp = bad_sp[$urandom_range(0, 4)];
      else if ($urandom_range(0, 3) == 0) sp = good_sp[$urandom_range(0, 2)];
      else if (rate_n(sp) == 0) sp = good_sp[$urandom_range(0, 2)];
      if ($urandom_range(0, 24) == 0) repeat (2) drive(1'b1, sp, 8'h00, 1'b0, 1'b0);
      flen = $urandom_range(1, 250);
      ilen = $urandom_range(0, 40);
      for (int i = 0; i < flen; i++) begin
        if ($urandom_range(0, 199) == 0) sp = good_sp[$urandom_range(0, 2)];
        drive(1'b0, sp, 8'($urandom), 1'b1, ($urandom_range(0, 15) == 0));
      end
      idle(sp, ilen);
    end

    idle(3'b100, 5);
    repeat (3) drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("strobe_queue_drained", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
